// File: rtl/cnn_pkg.sv
// ============================================================================
// cnn_pkg : shared data width, streamer state encoding and index-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package cnn_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Index width for a dimension of n entries; a 1-entry dimension still gets a 1-bit port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fmap_index_counter.sv
// ============================================================================
// fmap_index_counter : nested col/row/feature wrap counters advanced per transfer
// Rev 1.0
// ============================================================================
`default_nettype none

import cnn_pkg::*;

module fmap_index_counter #(
  parameter int IMAGE_WIDTH  = 12,
  parameter int IMAGE_HEIGHT = 12,
  parameter int NUM_FEATURES = 1
) (
  input  logic                            clk,
  input  logic                            rst_cnn,
  input  logic                            clr_i,
  input  logic                            adv_i,
  output logic [idx_w(IMAGE_WIDTH)-1:0]   col_o,
  output logic [idx_w(IMAGE_HEIGHT)-1:0]  row_o,
  output logic [idx_w(NUM_FEATURES)-1:0]  feat_o,
  output logic                            last_o
);

  localparam int COL_W  = idx_w(IMAGE_WIDTH);
  localparam int ROW_W  = idx_w(IMAGE_HEIGHT);
  localparam int FEAT_W = idx_w(NUM_FEATURES);

  localparam logic [COL_W-1:0]  C_COL_MAX  = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  C_ROW_MAX  = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [FEAT_W-1:0] C_FEAT_MAX = FEAT_W'(NUM_FEATURES - 1);

  logic [COL_W-1:0]  col_q,  col_d;
  logic [ROW_W-1:0]  row_q,  row_d;
  logic [FEAT_W-1:0] feat_q, feat_d;

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    feat_d = feat_q;
    if (clr_i) begin
      col_d  = '0;
      row_d  = '0;
      feat_d = '0;
    end else if (adv_i) begin
      // Feature also wraps so the counter is back at the origin after the final beat.
      if (col_q == C_COL_MAX) begin
        col_d = '0;
        if (row_q == C_ROW_MAX) begin
          row_d  = '0;
          feat_d = (feat_q == C_FEAT_MAX) ? '0 : feat_q + FEAT_W'(1);
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_cnn) begin
      col_q  <= '0;
      row_q  <= '0;
      feat_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      feat_q <= feat_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign feat_o = feat_q;
  assign last_o = (col_q == C_COL_MAX) && (row_q == C_ROW_MAX) && (feat_q == C_FEAT_MAX);

endmodule

`default_nettype wire

// File: rtl/fmap_streamer.sv
// ============================================================================
// fmap_streamer : streams feature-map pixels over a valid/ready handshake
// Optional build macro FMAP_STREAMER_RELU_EN clamps negative pixels to zero.
// Rev 1.0
// ============================================================================
`default_nettype none

import cnn_pkg::*;

module fmap_streamer #(
  parameter int IMAGE_WIDTH  = 12,
  parameter int IMAGE_HEIGHT = 12,
  parameter int NUM_FEATURES = 1
) (
  input  logic                            clk,
  input  logic                            rst_cnn,
  input  logic [DATA_W-1:0]               outfmap [NUM_FEATURES][IMAGE_HEIGHT][IMAGE_WIDTH],
  input  logic                            start,
  output logic [DATA_W-1:0]               pix_data,
  output logic                            pix_valid,
  input  logic                            pix_ready,
  output logic [idx_w(NUM_FEATURES)-1:0]  pix_feature,
  output logic [idx_w(IMAGE_HEIGHT)-1:0]  pix_row,
  output logic [idx_w(IMAGE_WIDTH)-1:0]   pix_col,
  output logic                            pix_last,
  output logic                            busy,
  output logic                            done
);

  state_t state_q;
  logic   valid_q;
  logic   busy_q;
  logic   done_q;

  logic              w_xfer;
  logic              w_at_last;
  logic [DATA_W-1:0] w_sel;

  assign w_xfer = valid_q & pix_ready;

  fmap_index_counter #(
    .IMAGE_WIDTH  (IMAGE_WIDTH),
    .IMAGE_HEIGHT (IMAGE_HEIGHT),
    .NUM_FEATURES (NUM_FEATURES)
  ) u_index (
    .clk     (clk),
    .rst_cnn (rst_cnn),
    .clr_i   (state_q != STREAM),
    .adv_i   (w_xfer),
    .col_o   (pix_col),
    .row_o   (pix_row),
    .feat_o  (pix_feature),
    .last_o  (w_at_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_cnn) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= STREAM;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        STREAM: begin
          if (w_xfer && w_at_last) begin
            state_q <= DONE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign w_sel = outfmap[pix_feature][pix_row][pix_col];

`ifdef FMAP_STREAMER_RELU_EN
  assign pix_data = w_sel[DATA_W-1] ? '0 : w_sel;
`else
  assign pix_data = w_sel;
`endif

  assign pix_valid = valid_q;
  assign pix_last  = valid_q & w_at_last;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fmap_streamer.sv
// ============================================================================
// tb_fmap_streamer : checks three streamer instances (12x12x1, 12x12x2, 1x1x1)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fmap_streamer;
  import cnn_pkg::*;

  localparam int W = 12;
  localparam int H = 12;
  localparam int N = W * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A: 12x12x1 with reference model ----------------
  logic        rst_a = 1'b0, start_a = 1'b0, ready_a = 1'b0;
  logic [31:0] fmap_a [1][H][W];
  logic [31:0] data_a;
  logic        valid_a, last_a, busy_a, done_a;
  logic [0:0]  feat_a;
  logic [3:0]  row_a, col_a;

  fmap_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .NUM_FEATURES(1)) dut_a (
    .clk(clk), .rst_cnn(rst_a), .outfmap(fmap_a), .start(start_a),
    .pix_data(data_a), .pix_valid(valid_a), .pix_ready(ready_a),
    .pix_feature(feat_a), .pix_row(row_a), .pix_col(col_a),
    .pix_last(last_a), .busy(busy_a), .done(done_a));

  // ---------------- instance B: 12x12x2 ----------------
  logic        rst_b = 1'b0, start_b = 1'b0, ready_b = 1'b0;
  logic [31:0] fmap_b [2][H][W];
  logic [31:0] data_b;
  logic        valid_b, last_b, busy_b, done_b;
  logic [0:0]  feat_b;
  logic [3:0]  row_b, col_b;

  fmap_streamer #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .NUM_FEATURES(2)) dut_b (
    .clk(clk), .rst_cnn(rst_b), .outfmap(fmap_b), .start(start_b),
    .pix_data(data_b), .pix_valid(valid_b), .pix_ready(ready_b),
    .pix_feature(feat_b), .pix_row(row_b), .pix_col(col_b),
    .pix_last(last_b), .busy(busy_b), .done(done_b));

  // ---------------- instance C: 1x1x1 ----------------
  logic        rst_c = 1'b0, start_c = 1'b0, ready_c = 1'b0;
  logic [31:0] fmap_c [1][1][1];
  logic [31:0] data_c;
  logic        valid_c, last_c, busy_c, done_c;
  logic [0:0]  feat_c, row_c, col_c;

  fmap_streamer #(.IMAGE_WIDTH(1), .IMAGE_HEIGHT(1), .NUM_FEATURES(1)) dut_c (
    .clk(clk), .rst_cnn(rst_c), .outfmap(fmap_c), .start(start_c),
    .pix_data(data_c), .pix_valid(valid_c), .pix_ready(ready_c),
    .pix_feature(feat_c), .pix_row(row_c), .pix_col(col_c),
    .pix_last(last_c), .busy(busy_c), .done(done_c));

  // Reference model for A: phase 0=idle 1=stream 2=done, k = flat beat index.
  int m_phase = 0;
  int m_k     = 0;
  int beats   = 0;

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef FMAP_STREAMER_RELU_EN
    return v[31] ? 32'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_a();
    int  f, r, c;
    logic st;
    st = (m_phase == 1);
    f  = st ? m_k / N : 0;
    r  = st ? (m_k / W) % H : 0;
    c  = st ? m_k % W : 0;
    chk("a_valid", {31'd0, valid_a}, {31'd0, st});
    chk("a_busy",  {31'd0, busy_a},  {31'd0, st});
    chk("a_done",  {31'd0, done_a},  (m_phase == 2) ? 32'd1 : 32'd0);
    chk("a_last",  {31'd0, last_a},  (st && m_k == N - 1) ? 32'd1 : 32'd0);
    chk("a_feat",  {31'd0, feat_a},  f);
    chk("a_row",   {28'd0, row_a},   r);
    chk("a_col",   {28'd0, col_a},   c);
    if (st) chk("a_data", data_a, relu(fmap_a[f][r][c]));
  endtask

  task automatic step_a();
    logic r, s, rd;
    r  = rst_a;
    s  = start_a;
    rd = ready_a;
    if (valid_a && rd && r) beats++;
    @(posedge clk);
    if (!r) begin
      m_phase = 0;
      m_k     = 0;
    end else begin
      case (m_phase)
        0: if (s) begin m_phase = 1; m_k = 0; end
        1: if (rd) begin
             if (m_k == N - 1) m_phase = 2;
             else m_k++;
           end
        default: m_phase = 0;
      endcase
    end
    #1;
    compare_a();
  endtask

  task automatic run_to_done(input int maxc, output int n);
    n = 0;
    while (!done_a && n < maxc) begin
      step_a();
      n++;
    end
    chk("a_done_reached", {31'd0, done_a}, 32'd1);
  endtask

  task automatic run_to_beats(input int target);
    int n;
    n = 0;
    while (beats < target && n < 500) begin
      step_a();
      n++;
    end
    chk("a_beat_reached", beats, target);
  endtask

  typedef struct {
    logic rst, start, ready;
    logic ev, eb, ed, el;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int n, nb;
    logic [31:0] held;

    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        fmap_a[0][r][c] = $urandom;
        fmap_b[0][r][c] = r * 12 + c;
        fmap_b[1][r][c] = 1000 + r * 12 + c;
      end
    fmap_a[0][0][2] = 32'hFFFF_FFF6;
    fmap_a[0][0][3] = 32'd7;
    fmap_c[0][0][0] = 32'd7;

    // Reset with start asserted: reset must win.
    start_a = 1'b1;
    step_a();
    start_a = 1'b0;
    step_a();
    rst_a = 1'b1;
    rst_b = 1'b1;
    step_a();

    // Continuous ready: 144 beats in 144 cycles.
    beats = 0;
    start_a = 1'b1;
    ready_a = 1'b1;
    step_a();
    start_a = 1'b0;
    n = 0;
    while (!done_a && n < 300) begin
      if (valid_a && row_a == 4'd0 && col_a == 4'd2)
        chk("relu_neg", data_a, relu(32'hFFFF_FFF6));
      if (valid_a && row_a == 4'd0 && col_a == 4'd3)
        chk("relu_pos", data_a, 32'd7);
      if (valid_a && last_a)
        chk("last_pos", {24'd0, feat_a, 3'd0, row_a, col_a}, {24'd0, 1'b0, 3'd0, 4'd11, 4'd11});
      step_a();
      n++;
    end
    chk("cycles_144", n, 144);
    chk("beats_144", beats, 144);
    step_a();

    // Three-cycle stall at beat 5.
    beats = 0;
    start_a = 1'b1;
    step_a();
    start_a = 1'b0;
    run_to_beats(4);
    held = data_a;
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step_a();
      chk("stall_col", {28'd0, col_a}, 32'd4);
      chk("stall_data", data_a, held);
    end
    ready_a = 1'b1;
    run_to_done(300, n);
    chk("stall_beats", beats, 144);
    step_a();

    // Second start mid-stream is ignored.
    beats = 0;
    start_a = 1'b1;
    step_a();
    start_a = 1'b0;
    run_to_beats(49);
    start_a = 1'b1;
    step_a();
    start_a = 1'b0;
    run_to_done(300, n);
    chk("restart_ignored_beats", beats, 144);
    step_a();
    step_a();

    // Reset mid-stream at beat 70, then restart.
    beats = 0;
    start_a = 1'b1;
    step_a();
    start_a = 1'b0;
    run_to_beats(69);
    rst_a = 1'b0;
    step_a();
    rst_a = 1'b1;
    chk("rst_valid", {31'd0, valid_a}, 32'd0);
    chk("rst_busy",  {31'd0, busy_a},  32'd0);
    chk("rst_col",   {28'd0, col_a},   32'd0);
    step_a();
    beats = 0;
    start_a = 1'b1;
    step_a();
    start_a = 1'b0;
    chk("restart_valid", {31'd0, valid_a}, 32'd1);
    chk("restart_idx", {24'd0, feat_a, 3'd0, row_a, col_a}, 32'd0);
    run_to_done(300, n);
    chk("restart_beats", beats, 144);

    // Randomised handshake, start pulses and rare resets against the model.
    for (int i = 0; i < 2000; i++) begin
      ready_a = ($urandom_range(0, 3) != 0);
      start_a = ($urandom_range(0, 19) == 0);
      rst_a   = ($urandom_range(0, 299) != 0);
      step_a();
    end
    rst_a = 1'b1;
    start_a = 1'b0;
    ready_a = 1'b1;
    for (int i = 0; i < 200; i++) step_a();

    // Two feature maps: beat 145 is the first pixel of feature 1.
    start_b = 1'b1;
    ready_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    nb = 0;
    for (int i = 0; i < 400 && !done_b; i++) begin
      if (valid_b) begin
        nb++;
        if (nb == 145) begin
          chk("b145_data", data_b, 32'd1000);
          chk("b145_idx", {24'd0, feat_b, 3'd0, row_b, col_b}, {24'd0, 1'b1, 3'd0, 4'd0, 4'd0});
        end
      end
      @(posedge clk); #1;
    end
    chk("b_beats", nb, 288);
    chk("b_done", {31'd0, done_b}, 32'd1);

    // 1x1x1 cycle table: {rst,start,ready} -> {valid,busy,done,last}.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rst_c   = tbl[i].rst;
      start_c = tbl[i].start;
      ready_c = tbl[i].ready;
      @(posedge clk); #1;
      chk($sformatf("c%0d_valid", i), {31'd0, valid_c}, {31'd0, tbl[i].ev});
      chk($sformatf("c%0d_busy", i),  {31'd0, busy_c},  {31'd0, tbl[i].eb});
      chk($sformatf("c%0d_done", i),  {31'd0, done_c},  {31'd0, tbl[i].ed});
      chk($sformatf("c%0d_last", i),  {31'd0, last_c},  {31'd0, tbl[i].el});
      if (tbl[i].ev) chk($sformatf("c%0d_data", i), data_c, 32'd7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
